// File: rtl/clause_status_ctrl_pkg.sv
// Shared types and encodings for the clause status controller.
package clause_status_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StEval,
    StImply,
    StSettle,
    StDone,
    StConflict
  } state_e;

  localparam logic [1:0] ST_UNDET = 2'b00;
  localparam logic [1:0] ST_SAT   = 2'b01;
  localparam logic [1:0] ST_UNIT  = 2'b10;
  localparam logic [1:0] ST_CONF  = 2'b11;

  localparam logic [1:0] FLC_NONE = 2'b00;
  localparam logic [1:0] FLC_ONE  = 2'b01;
  localparam logic [1:0] FLC_MANY = 2'b11;

endpackage

// File: rtl/clause_status_ctrl_sat_cnt.sv
// Generic saturating up-counter with synchronous clear.
module clause_status_ctrl_sat_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/clause_status_ctrl.sv
// Per-clause control stage: classifies the clause, drives implication/conflict
// into the literal chain and reports the result with a start/done/ack handshake.
module clause_status_ctrl
  import clause_status_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LITS      = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                ack_i,
  input  logic                clear_i,
  input  logic [1:0]          freelitcnt_i,
  input  logic [NUM_LITS-1:0] clausesat_i,
  input  logic [NUM_LITS-1:0] cclause_i,
  output logic                imp_drv_o,
  output logic                cclause_drv_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [1:0]          status_o,
  output logic [CNT_W-1:0]    imp_cnt_o
);

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

  state_e     state_q;
  logic [3:0] settle_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      settle_cnt_q  <= '0;
      imp_drv_o     <= 1'b0;
      cclause_drv_o <= 1'b0;
      done_o        <= 1'b0;
      status_o      <= ST_UNDET;
    end else if (clear_i) begin
      state_q       <= StIdle;
      settle_cnt_q  <= '0;
      imp_drv_o     <= 1'b0;
      cclause_drv_o <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      // Implication drive is a one-cycle pulse covering only the IMPLY state.
      imp_drv_o <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) state_q <= StEval;
        end
        StEval: begin
          if (|clausesat_i) begin
            state_q  <= StDone;
            status_o <= ST_SAT;
            done_o   <= 1'b1;
          end else if (freelitcnt_i == FLC_NONE) begin
            state_q       <= StConflict;
            status_o      <= ST_CONF;
            done_o        <= 1'b1;
            cclause_drv_o <= 1'b1;
          end else if (freelitcnt_i == FLC_ONE) begin
            state_q   <= StImply;
            imp_drv_o <= 1'b1;
          end else begin
            // FLC_MANY and the unused code 2'b10 both mean undetermined.
            state_q  <= StDone;
            status_o <= ST_UNDET;
            done_o   <= 1'b1;
          end
        end
        StImply: begin
          state_q      <= StSettle;
          settle_cnt_q <= SettleLoad;
        end
        StSettle: begin
          if (|cclause_i) begin
            state_q       <= StConflict;
            status_o      <= ST_CONF;
            done_o        <= 1'b1;
            cclause_drv_o <= 1'b1;
          end else if (settle_cnt_q == 4'd0) begin
            state_q  <= StDone;
            status_o <= ST_UNIT;
            done_o   <= 1'b1;
          end else begin
            settle_cnt_q <= settle_cnt_q - 4'd1;
          end
        end
        StDone: begin
          if (ack_i) begin
            state_q <= StIdle;
            done_o  <= 1'b0;
          end
        end
        StConflict: begin
          if (ack_i) begin
            state_q       <= StIdle;
            done_o        <= 1'b0;
            cclause_drv_o <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = (state_q != StIdle);

  clause_status_ctrl_sat_cnt #(
    .Width (CNT_W)
  ) u_imp_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear_i),
    .inc_i   (state_q == StImply),
    .count_o (imp_cnt_o)
  );

endmodule

// File: tb/tb_clause_status_ctrl.sv
// Directed self-checking bench for clause_status_ctrl.
module tb_clause_status_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i, ack_i, clear_i;
  logic [1:0] freelitcnt_i;
  logic [7:0] clausesat_i, cclause_i;
  logic       imp_drv_o, cclause_drv_o, busy_o, done_o;
  logic [1:0] status_o;
  logic [7:0] imp_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clause_status_ctrl #(
    .NUM_LITS      (8),
    .SETTLE_CYCLES (2),
    .CNT_W         (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .ack_i         (ack_i),
    .clear_i       (clear_i),
    .freelitcnt_i  (freelitcnt_i),
    .clausesat_i   (clausesat_i),
    .cclause_i     (cclause_i),
    .imp_drv_o     (imp_drv_o),
    .cclause_drv_o (cclause_drv_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .status_o      (status_o),
    .imp_cnt_o     (imp_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    start_i = 0; ack_i = 0; clear_i = 0;
    freelitcnt_i = 2'b11; clausesat_i = '0; cclause_i = '0;
    #3;
    check("rst_imp_drv", imp_drv_o, 0);
    check("rst_cdrv", cclause_drv_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_status", status_o, 0);
    check("rst_cnt", imp_cnt_o, 0);
    tick(2);
    rst = 1'b1;
    tick();

    // Satisfied clause: done two cycles after start.
    clausesat_i = 8'h04; freelitcnt_i = 2'b01;
    pulse_start();
    check("sat_eval_busy", busy_o, 1);
    check("sat_eval_done", done_o, 0);
    tick();
    check("sat_done", done_o, 1);
    check("sat_status", status_o, 2'b01);
    check("sat_imp_drv", imp_drv_o, 0);
    check("sat_cnt", imp_cnt_o, 0);
    tick(2);
    check("sat_hold", done_o, 1);
    do_ack();
    check("sat_ack_done", done_o, 0);
    check("sat_ack_busy", busy_o, 0);
    check("sat_status_kept", status_o, 2'b01);
    clausesat_i = '0;

    // Undetermined, including the unused 2'b10 code.
    freelitcnt_i = 2'b11;
    pulse_start(); tick();
    check("undet_done", done_o, 1);
    check("undet_status", status_o, 2'b00);
    do_ack();
    freelitcnt_i = 2'b10;
    clausesat_i = 8'h80; pulse_start(); tick(); do_ack();
    clausesat_i = '0; pulse_start(); tick();
    check("flc10_status", status_o, 2'b00);
    check("flc10_imp_drv", imp_drv_o, 0);
    do_ack();

    // Unit clause, no conflict: done five cycles after start.
    freelitcnt_i = 2'b01;
    pulse_start();
    check("unit_eval_imp", imp_drv_o, 0);
    tick();
    check("unit_imply_imp", imp_drv_o, 1);
    check("unit_imply_done", done_o, 0);
    tick();
    check("unit_settle1_imp", imp_drv_o, 0);
    check("unit_cnt", imp_cnt_o, 1);
    tick();
    check("unit_settle2_done", done_o, 0);
    tick();
    check("unit_done", done_o, 1);
    check("unit_status", status_o, 2'b10);
    check("unit_cdrv", cclause_drv_o, 0);
    // ack together with start: start dropped
    ack_i = 1'b1; start_i = 1'b1; tick(); ack_i = 1'b0; start_i = 1'b0;
    check("ackstart_done", done_o, 0);
    tick();
    check("ackstart_busy", busy_o, 0);

    // Unit clause with conflict in the second settle cycle.
    pulse_start(); tick(3);
    check("uconf_pre_done", done_o, 0);
    cclause_i = 8'h01;
    tick();
    cclause_i = '0;
    check("uconf_done", done_o, 1);
    check("uconf_status", status_o, 2'b11);
    check("uconf_cdrv", cclause_drv_o, 1);
    check("uconf_cnt", imp_cnt_o, 2);
    tick(3);
    check("uconf_hold_cdrv", cclause_drv_o, 1);
    do_ack();
    check("uconf_ack_cdrv", cclause_drv_o, 0);
    check("uconf_ack_done", done_o, 0);

    // Empty clause.
    freelitcnt_i = 2'b00;
    pulse_start();
    check("empty_eval_done", done_o, 0);
    tick();
    check("empty_done", done_o, 1);
    check("empty_status", status_o, 2'b11);
    check("empty_cdrv", cclause_drv_o, 1);
    check("empty_cnt", imp_cnt_o, 2);
    do_ack();

    // ack outside DONE/CONFLICT is ignored.
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    check("idle_ack_busy", busy_o, 0);

    // Saturation: 260 more unit evaluations.
    freelitcnt_i = 2'b01;
    for (int k = 0; k < 260; k++) begin
      pulse_start(); tick(4); do_ack();
      if (k == 252) check("cnt_at_255", imp_cnt_o, 8'hFF);
    end
    check("cnt_sat", imp_cnt_o, 8'hFF);
    check("sat_last_status", status_o, 2'b10);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check("clr_cnt", imp_cnt_o, 0);
    check("clr_busy", busy_o, 0);

    // Clear with start during SETTLE.
    pulse_start(); tick(2);
    check("clr_settle_busy", busy_o, 1);
    clear_i = 1'b1; start_i = 1'b1; tick(); clear_i = 1'b0; start_i = 1'b0;
    check("clrs_busy", busy_o, 0);
    check("clrs_done", done_o, 0);
    check("clrs_imp", imp_drv_o, 0);
    check("clrs_cnt", imp_cnt_o, 0);
    tick(6);
    check("clrs_busy_later", busy_o, 0);
    check("clrs_done_later", done_o, 0);

    // Reset mid-CONFLICT drops drives without a clock edge.
    freelitcnt_i = 2'b00;
    pulse_start(); tick();
    check("rconf_cdrv", cclause_drv_o, 1);
    #2 rst = 1'b0;
    #1;
    check("rconf_async_cdrv", cclause_drv_o, 0);
    check("rconf_async_done", done_o, 0);
    check("rconf_async_busy", busy_o, 0);
    check("rconf_async_status", status_o, 0);
    tick();
    rst = 1'b1;
    tick();
    check("rconf_after_busy", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
